// File: rtl/sha2_pkg.sv
// -----------------------------------------------------------------------------
// sha2_pkg
// Shared definitions for the SHA-2 round-constant source.
//   K256 : the 64 SHA-224/256 round constants (32-bit, FIPS 180-4)
//   K512 : the 80 SHA-384/512 round constants (64-bit, FIPS 180-4)
//   NUM_ROUNDS_256 / NUM_ROUNDS_512 : sequence lengths of the two families
//   kseq_state_e : state encoding of the K-stream sequencer
// The 256 table is kept as its own constant array rather than being derived
// from the upper halves of K512, so the 32-bit ROM carries no 64-bit storage.
// -----------------------------------------------------------------------------
package sha2_pkg;

    localparam int NUM_ROUNDS_256 = 64;
    localparam int NUM_ROUNDS_512 = 80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } kseq_state_e;

    localparam logic [31:0] K256 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd,
        64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019,
        64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe,
        64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
        64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
        64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
        64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210,
        64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
        64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
        64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
        64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
        64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910,
        64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
        64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
        64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
        64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9,
        64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207,
        64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
        64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493,
        64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
        64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

endpackage

// File: rtl/sha2_k_rom.sv
// -----------------------------------------------------------------------------
// sha2_k_rom
// Combinational round-constant lookup for one SHA-2 family.
//   MODE_512 : 0 = 64 x 32-bit table, 1 = 80 x 64-bit table
//   idx      : in  7      round index
//   k        : out WORD_W K[idx], zero when idx is out of range
//   oor      : out 1      idx >= NUM_ROUNDS
// -----------------------------------------------------------------------------
module sha2_k_rom
    import sha2_pkg::*;
#(
    parameter bit  MODE_512   = 1'b0,
    localparam int WORD_W     = MODE_512 ? 64 : 32,
    localparam int NUM_ROUNDS = MODE_512 ? NUM_ROUNDS_512 : NUM_ROUNDS_256
) (
    input  logic [6:0]        idx,
    output logic [WORD_W-1:0] k,
    output logic              oor
);

    if (MODE_512) begin : g_512
        // 80-entry lookup; indices 80..127 return zero and flag out-of-range
        always_comb begin
            k   = '0;
            oor = 1'b0;
            if (idx >= 7'(NUM_ROUNDS)) begin
                oor = 1'b1;
            end else begin
                k = K512[idx];
            end
        end
    end else begin : g_256
        // 64-entry lookup; bit 6 of the index alone marks out-of-range
        always_comb begin
            k   = '0;
            oor = 1'b0;
            if (idx[6]) begin
                oor = 1'b1;
            end else begin
                k = K256[idx[5:0]];
            end
        end
    end

endmodule

// File: rtl/sha2_kconst_seq.sv
// -----------------------------------------------------------------------------
// sha2_kconst_seq
// SHA-2 round-constant source: streams K[0..NUM_ROUNDS-1] over valid/ready and
// serves a registered random-access read port with 1-cycle latency.
//   clk, rst_n         : clock, synchronous active-low reset
//   start / abort      : begin a sequence (IDLE only) / drop the sequence
//   k_valid, k_ready   : stream handshake
//   k_data, k_round    : current beat constant and its round index
//   k_last             : current beat is round NUM_ROUNDS-1
//   busy / done        : sequence running / one-cycle end-of-sequence pulse
//   rd_en, rd_addr     : random-access strobe and index
//   rd_data, rd_valid  : K[rd_addr] (registered) and its qualifier
//   rd_err             : rd_addr was out of range at the strobe
// -----------------------------------------------------------------------------
module sha2_kconst_seq
    import sha2_pkg::*;
#(
    parameter bit  MODE_512   = 1'b0,
    localparam int WORD_W     = MODE_512 ? 64 : 32,
    localparam int NUM_ROUNDS = MODE_512 ? NUM_ROUNDS_512 : NUM_ROUNDS_256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              k_valid,
    input  logic              k_ready,
    output logic [WORD_W-1:0] k_data,
    output logic [6:0]        k_round,
    output logic              k_last,
    output logic              busy,
    output logic              done,
    input  logic              rd_en,
    input  logic [6:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err
);

    localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

    kseq_state_e       state_q,    state_d;
    logic              k_valid_q,  k_valid_d;
    logic [WORD_W-1:0] k_data_q,   k_data_d;
    logic [6:0]        k_round_q,  k_round_d;
    logic              k_last_q,   k_last_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [WORD_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q,   rd_err_d;

    logic [6:0]        stream_idx_s;
    logic [WORD_W-1:0] stream_k_s;
    logic              stream_oor_s;
    logic [WORD_W-1:0] rd_k_s;
    logic              rd_oor_s;

    // Two ROM copies so the stream and the random port never contend
    sha2_k_rom #(.MODE_512(MODE_512)) u_rom_stream (
        .idx (stream_idx_s),
        .k   (stream_k_s),
        .oor (stream_oor_s)
    );

    sha2_k_rom #(.MODE_512(MODE_512)) u_rom_rd (
        .idx (rd_addr),
        .k   (rd_k_s),
        .oor (rd_oor_s)
    );

    // Index of the beat that would be presented next: K[0] on a start,
    // K[k_round+1] on an advance. It runs off the table only while the
    // last beat is on the bus, which is how the last beat is recognised.
    always_comb begin
        if (state_q == ST_RUN) begin
            stream_idx_s = k_round_q + 7'd1;
        end else begin
            stream_idx_s = 7'd0;
        end
    end

    // Sequencer next-state and stream output computation
    always_comb begin
        state_d   = state_q;
        k_valid_d = k_valid_q;
        k_data_d  = k_data_q;
        k_round_d = k_round_q;
        k_last_d  = k_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d   = ST_RUN;
                    k_valid_d = 1'b1;
                    k_round_d = 7'd0;
                    k_data_d  = stream_k_s;
                    k_last_d  = (LAST_ROUND == 7'd0);
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    k_valid_d = 1'b0;
                    k_last_d  = 1'b0;
                    busy_d    = 1'b0;
                end else if (k_ready) begin
                    if (stream_oor_s) begin
                        // last beat accepted; data/round keep their values
                        state_d   = ST_IDLE;
                        k_valid_d = 1'b0;
                        k_last_d  = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        k_round_d = stream_idx_s;
                        k_data_d  = stream_k_s;
                        k_last_d  = (stream_idx_s == LAST_ROUND);
                    end
                end else begin
                    // stalled: hold the beat unchanged
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                k_valid_d = 1'b0;
                k_last_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Random-access port next values; independent of the sequencer
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        rd_err_d   = 1'b0;
        if (rd_en) begin
            rd_data_d = rd_oor_s ? '0 : rd_k_s;
            rd_err_d  = rd_oor_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_valid_q  <= 1'b0;
            k_data_q   <= '0;
            k_round_q  <= 7'd0;
            k_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_valid_q  <= k_valid_d;
            k_data_q   <= k_data_d;
            k_round_q  <= k_round_d;
            k_last_q   <= k_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign k_valid  = k_valid_q;
    assign k_data   = k_data_q;
    assign k_round  = k_round_q;
    assign k_last   = k_last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_sha2_kconst_seq.sv
// -----------------------------------------------------------------------------
// tb_sha2_kconst_seq
// Drives a SHA-256 instance and a SHA-512 instance from shared stimulus and
// checks both every cycle against a behavioural model. The model's constants
// are computed from their definition: the fractional bits of the cube roots
// of the first 80 primes.
// -----------------------------------------------------------------------------
module tb_sha2_kconst_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        k_ready;
    logic        rd_en;
    logic [6:0]  rd_addr;

    logic        k_valid0, k_last0, busy0, done0, rd_valid0, rd_err0;
    logic [31:0] k_data0, rd_data0;
    logic [6:0]  k_round0;
    logic        k_valid1, k_last1, busy1, done1, rd_valid1, rd_err1;
    logic [63:0] k_data1, rd_data1;
    logic [6:0]  k_round1;

    int checks = 0;
    int errors = 0;

    // model state and expected outputs, index 0 = SHA-256, 1 = SHA-512
    logic [63:0] k512_m [80];
    logic [31:0] k256_m [64];
    logic        e_valid [2];
    logic [63:0] e_data [2];
    logic [6:0]  e_round [2];
    logic        e_last [2];
    logic        e_busy [2];
    logic        e_done [2];
    logic [63:0] e_rdata [2];
    logic        e_rvalid [2];
    logic        e_rerr [2];
    logic [6:0]  e_raddr [2];

    sha2_kconst_seq #(.MODE_512(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .k_valid(k_valid0), .k_ready(k_ready), .k_data(k_data0),
        .k_round(k_round0), .k_last(k_last0), .busy(busy0), .done(done0),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .rd_err(rd_err0)
    );

    sha2_kconst_seq #(.MODE_512(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .k_valid(k_valid1), .k_ready(k_ready), .k_data(k_data1),
        .k_round(k_round1), .k_last(k_last1), .busy(busy1), .done(done1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .rd_err(rd_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // floor(cbrt(p) * 2^64) mod 2^64, by bitwise integer cube root
    function automatic logic [63:0] cbrt_frac(input int unsigned p);
        logic [255:0] tgt, r, t, cube;
        tgt = 256'(p) << 192;
        r   = '0;
        for (int b = 68; b >= 0; b--) begin
            t    = r | (256'(1) << b);
            cube = t * t * t;
            if (cube <= tgt) r = t;
        end
        return r[63:0];
    endfunction

    function automatic int nrounds(input int m);
        return (m == 0) ? 64 : 80;
    endfunction

    function automatic logic [63:0] kmod(input int m, input int idx);
        return (m == 0) ? {32'h0, k256_m[idx]} : k512_m[idx];
    endfunction

    task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", name, m, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Behavioural model: advances on every rising edge from the inputs
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                e_valid[m]  <= 1'b0;  e_data[m]   <= 64'h0;
                e_round[m]  <= 7'd0;  e_last[m]   <= 1'b0;
                e_busy[m]   <= 1'b0;  e_done[m]   <= 1'b0;
                e_rdata[m]  <= 64'h0; e_rvalid[m] <= 1'b0;
                e_rerr[m]   <= 1'b0;  e_raddr[m]  <= 7'd0;
            end else begin
                e_done[m] <= 1'b0;
                if (e_busy[m]) begin
                    if (abort) begin
                        e_busy[m] <= 1'b0; e_valid[m] <= 1'b0; e_last[m] <= 1'b0;
                    end else if (k_ready) begin
                        if (int'(e_round[m]) == nrounds(m) - 1) begin
                            e_busy[m] <= 1'b0; e_valid[m] <= 1'b0;
                            e_last[m] <= 1'b0; e_done[m]  <= 1'b1;
                        end else begin
                            e_round[m] <= e_round[m] + 7'd1;
                            e_data[m]  <= kmod(m, int'(e_round[m]) + 1);
                            e_last[m]  <= (int'(e_round[m]) + 1 == nrounds(m) - 1);
                        end
                    end
                end else if (start && !abort) begin
                    e_busy[m]  <= 1'b1; e_valid[m] <= 1'b1;
                    e_round[m] <= 7'd0; e_data[m]  <= kmod(m, 0);
                    e_last[m]  <= 1'b0;
                end
                e_rvalid[m] <= rd_en;
                e_raddr[m]  <= rd_addr;
                if (rd_en) begin
                    if (int'(rd_addr) < nrounds(m)) begin
                        e_rdata[m] <= kmod(m, int'(rd_addr)); e_rerr[m] <= 1'b0;
                    end else begin
                        e_rdata[m] <= 64'h0; e_rerr[m] <= 1'b1;
                    end
                end else begin
                    e_rerr[m] <= 1'b0;
                end
            end
        end
    end

    task automatic cmp_inst(input int m, input logic v, input logic [63:0] d, input logic [6:0] r,
                            input logic l, input logic b, input logic dn,
                            input logic [63:0] rd, input logic rv, input logic re);
        chk("k_valid",  m, 64'(v),  64'(e_valid[m]));
        chk("k_data",   m, d,       e_data[m]);
        chk("k_round",  m, 64'(r),  64'(e_round[m]));
        chk("k_last",   m, 64'(l),  64'(e_last[m]));
        chk("busy",     m, 64'(b),  64'(e_busy[m]));
        chk("done",     m, 64'(dn), 64'(e_done[m]));
        chk("rd_data",  m, rd,      e_rdata[m]);
        chk("rd_valid", m, 64'(rv), 64'(e_rvalid[m]));
        chk("rd_err",   m, 64'(re), 64'(e_rerr[m]));
    endtask

    // Compare process: every falling edge, plus literal pins at key beats
    always @(negedge clk) begin
        cmp_inst(0, k_valid0, {32'h0, k_data0}, k_round0, k_last0, busy0, done0,
                 {32'h0, rd_data0}, rd_valid0, rd_err0);
        cmp_inst(1, k_valid1, k_data1, k_round1, k_last1, busy1, done1,
                 rd_data1, rd_valid1, rd_err1);
        if (e_valid[0] && e_round[0] == 7'd1)  chk("lit256_k1",  0, 64'(k_data0), 64'h71374491);
        if (e_valid[0] && e_round[0] == 7'd63) begin
            chk("lit256_k63", 0, 64'(k_data0), 64'hc67178f2);
            chk("lit256_last", 0, 64'(k_last0), 64'h1);
        end
        if (e_valid[1] && e_round[1] == 7'd79) begin
            chk("lit512_k79", 1, k_data1, 64'h6c44198c4a475817);
            chk("lit512_last", 1, 64'(k_last1), 64'h1);
        end
        if (e_rvalid[0] && e_raddr[0] == 7'd63) chk("lit_rd63", 0, 64'(rd_data0), 64'hc67178f2);
        if (e_rvalid[0] && e_raddr[0] == 7'd70) begin
            chk("lit_rd70_data", 0, 64'(rd_data0), 64'h0);
            chk("lit_rd70_err",  0, 64'(rd_err0),  64'h1);
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (busy0 || busy1); i++) step();
        chk("idle_timeout", 0, 64'(busy0 || busy1), 64'h0);
    endtask

    initial begin
        int       n;
        int       cnt;
        bit       is_p;
        bit       restarted;
        int unsigned primes [80];

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        k_ready = 1'b0; rd_en = 1'b0; rd_addr = 7'd0;

        // first 80 primes, then the constants from their cube roots
        n = 2; cnt = 0;
        while (cnt < 80) begin
            is_p = 1'b1;
            for (int d = 2; d * d <= n; d++) if (n % d == 0) is_p = 1'b0;
            if (is_p) begin primes[cnt] = n; cnt++; end
            n++;
        end
        for (int i = 0; i < 80; i++) k512_m[i] = cbrt_frac(primes[i]);
        for (int i = 0; i < 64; i++) k256_m[i] = k512_m[i][63:32];
        chk("model_k512_0",  1, k512_m[0],  64'h428a2f98d728ae22);
        chk("model_k512_1",  1, k512_m[1],  64'h7137449123ef65cd);
        chk("model_k512_79", 1, k512_m[79], 64'h6c44198c4a475817);
        chk("model_k256_63", 0, 64'(k256_m[63]), 64'hc67178f2);

        repeat (3) step();
        rst_n = 1'b1;
        step();

        // full-throughput stream; restart on the done cycle of SHA-256;
        // random reads of 63 and 70 while both streams run
        k_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("first_beat0", 0, 64'(k_data0), 64'h428a2f98);
        chk("first_beat1", 1, k_data1, 64'h428a2f98d728ae22);
        restarted = 1'b0;
        for (int i = 0; i < 400 && (busy0 || busy1 || !restarted); i++) begin
            rd_en   = (i == 20 || i == 21);
            rd_addr = (i == 21) ? 7'd70 : 7'd63;
            start   = done0 && !restarted;
            if (done0) restarted = 1'b1;
            step();
        end
        start = 1'b0; rd_en = 1'b0;
        chk("restart_seen", 0, 64'(restarted), 64'h1);
        wait_idle(200);

        // random backpressure with random reads
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 800 && (busy0 || busy1); i++) begin
            k_ready = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 7'($urandom_range(0, 127));
            step();
        end
        k_ready = 1'b1; rd_en = 1'b0;
        wait_idle(200);

        // abort at round 10, then restart from round 0
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !(k_valid0 && k_round0 == 7'd10); i++) step();
        chk("reach_round10", 0, 64'(k_round0), 64'd10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 0, 64'(k_valid0), 64'h0);
        chk("abort_busy",  1, 64'(busy1),    64'h0);
        step();
        chk("abort_nodone", 0, 64'(done0), 64'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_round", 0, 64'(k_round0), 64'h0);
        chk("restart_data",  0, 64'(k_data0),  64'h428a2f98);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // start together with abort in IDLE stays IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 0, 64'(busy0 || k_valid0), 64'h0);

        // reset mid-stream
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk("rst_stream_valid", 0, 64'(k_valid0), 64'h0);
        chk("rst_stream_data",  1, k_data1,       64'h0);
        rst_n = 1'b1;

        // reset mid-stall with a read in flight
        start = 1'b1;
        step();
        start = 1'b0; k_ready = 1'b0; rd_en = 1'b1; rd_addr = 7'd5;
        repeat (4) step();
        rst_n = 1'b0; rd_en = 1'b0;
        step();
        chk("rst_stall_round", 0, 64'(k_round0), 64'h0);
        chk("rst_stall_rd",    1, rd_data1,      64'h0);
        rst_n = 1'b1; k_ready = 1'b1;
        step();

        // random mix of everything
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 31) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            k_ready = ($urandom_range(0, 3) != 0);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 7'($urandom_range(0, 127));
            step();
        end
        start = 1'b0; abort = 1'b0; rst_n = 1'b1; k_ready = 1'b1; rd_en = 1'b0;
        wait_idle(200);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
